alu_iterative: RTL

Execute-stage ALU that consumes the 3-bit control code produced by `ALU_Control`, together with the two register-file/immediate operands, and returns a 32-bit result. Single-cycle operations (AND, XOR, SLL, ADD, SUB, SRA) return a registered result one cycle after acceptance. MUL runs on an iterative shift-add datapath over 32 cycles. A valid/ready handshake lets the core stall while a multiply is in flight.

---
 rtl/alu_iterative.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_iterative.sv
// alu_iterative
//   Execute-stage ALU. Single-cycle ops (AND, XOR, SLL, ADD, SUB, SRA) return
//   a registered result one cycle after acceptance. MUL runs on a 32-cycle
//   shift-add datapath, and ready_o drops while it is running.
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous reset, active low
//   valid_i    in   request, sampled only while ready_o=1
//   ready_o    out  block can accept a request this cycle (state==IDLE)
//   ALUCtrl_i  in   op code: AND=000 XOR=001 SLL=010 ADD=011 SUB=100
//                   MUL=101 SRA=110 (111 reserved -> result 0)
//   data1_i    in   operand A
//   data2_i    in   operand B
//   valid_o    out  one-cycle pulse when data_o takes a new result
//   data_o     out  result, held until the next result is written
//   zero_o     out  registered (data_o == 0)
module alu_iterative (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  ALUCtrl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        zero_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mplier, acc;
  logic [4:0]  cnt;
  logic [31:0] op_res;
  logic [31:0] acc_sum;
  logic        accept;
  logic        is_mul;
  logic        mul_last;

  assign ready_o  = (state == S_IDLE);
  assign accept   = valid_i & ready_o;
  assign is_mul   = (ALUCtrl_i == OP_MUL);
  assign mul_last = (cnt == 5'd31);

  // Partial-product step; on the final iteration this sum is the result.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  // Single-cycle result. MUL and reserved codes fall to 0 here; MUL never
  // writes op_res.
  always_comb begin
    op_res = '0;
    case (ALUCtrl_i)
      OP_AND:  op_res = data1_i & data2_i;
      OP_XOR:  op_res = data1_i ^ data2_i;
      OP_SLL:  op_res = data1_i << data2_i[4:0];
      OP_ADD:  op_res = data1_i + data2_i;
      OP_SUB:  op_res = data1_i - data2_i;
      OP_SRA:  op_res = $unsigned($signed(data1_i) >>> data2_i[4:0]);
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:   if (mul_last)         state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      data_o  <= '0;
      zero_o  <= 1'b1;
      valid_o <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= data1_i;
              mplier <= data2_i;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              data_o  <= op_res;
              zero_o  <= (op_res == 32'd0);
              valid_o <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (mul_last) begin
            data_o  <= acc_sum;
            zero_o  <= (acc_sum == 32'd0);
            valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
